// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg -- shared fetch-state encodings and PC constants.
// Rev 1.0
`default_nettype none

package pc_fetch_unit_pkg;

  localparam logic [1:0] FETCH_RUN  = 2'd0;
  localparam logic [1:0] FETCH_WAIT = 2'd1;
  localparam logic [1:0] FETCH_DROP = 2'd2;

  localparam int PC_INCR = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_fetch_buffer.sv
// fetch_buffer -- circular FIFO of {pc, inst} pairs; flush overrides push/pop.
// Rev 1.0
`default_nettype none

module fetch_buffer #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [PC_W-1:0]          i_pc,
  input  logic [DATA_W-1:0]        i_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [PC_W-1:0]          o_pc,
  output logic [DATA_W-1:0]        o_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]   r_mem_pc   [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W:0]    r_count;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop)
        r_count <= r_count + 1'b1;
      else if (!i_push && i_pop)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem_pc[r_wr_ptr]   <= i_pc;
      r_mem_data[r_wr_ptr] <= i_data;
    end
  end

  // Head reads as zero while empty so decode never sees stale entries.
  assign o_count = r_count;
  assign o_pc    = (r_count != '0) ? r_mem_pc[r_rd_ptr]   : '0;
  assign o_data  = (r_count != '0) ? r_mem_data[r_rd_ptr] : '0;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit -- owns the fetch PC, issues one in-order fetch at a time, buffers results for decode.
// Rev 1.0
`default_nettype none

module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                INST_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_enable,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc_o
);

  localparam int                CNT_W       = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  c_BUF_DEPTH = CNT_W'(BUF_DEPTH);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_orphan;

  logic [CNT_W-1:0]  w_count;
  logic              w_push;
  logic              w_pop;
  logic              w_accept;
  logic [ADDR_W-1:0] w_target;

  assign w_target = jump_target & ~ADDR_W'(3);

  assign imem_req_valid = !rst && !jump_enable && (r_state == FETCH_RUN) && (w_count < c_BUF_DEPTH);
  assign imem_req_addr  = r_pc;
  assign pc_o           = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  assign inst_valid = !rst && !jump_enable && (w_count != '0);
  assign w_pop      = inst_valid && inst_ready;
  assign w_push     = !jump_enable && (r_state == FETCH_WAIT) && imem_rsp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= FETCH_RUN;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
    end else if (jump_enable) begin
      r_pc <= w_target;
      // A response landing in the redirect cycle retires the outstanding fetch.
      if (r_state == FETCH_WAIT)
        r_state <= imem_rsp_valid ? FETCH_RUN : FETCH_DROP;
      else if (r_state == FETCH_DROP && imem_rsp_valid)
        r_state <= FETCH_RUN;
    end else begin
      case (r_state)
        FETCH_RUN: begin
          if (w_accept) begin
            r_pc     <= r_pc + ADDR_W'(PC_INCR);
            r_req_pc <= r_pc;
            r_state  <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: if (imem_rsp_valid) r_state <= FETCH_RUN;
        FETCH_DROP: if (imem_rsp_valid) r_state <= FETCH_RUN;
        default:    r_state <= FETCH_RUN;
      endcase
    end
  end

  // Remembers that a reset abandoned an in-flight fetch, so its late response is expected.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (r_state != FETCH_RUN) r_orphan <= TRUE;
    end else if (imem_rsp_valid) begin
      r_orphan <= FALSE;
    end
  end

  fetch_buffer #(
    .PC_W   (ADDR_W),
    .DATA_W (INST_W),
    .DEPTH  (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk     (clk),
    .rst     (rst),
    .i_flush (jump_enable),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_pc    (r_req_pc),
    .i_data  (imem_rsp_data),
    .o_count (w_count),
    .o_pc    (inst_pc),
    .o_data  (inst_data)
  );

  a_no_rsp_in_run: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (r_state == FETCH_RUN) && !r_orphan));

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit -- randomized and directed checks of pc_fetch_unit against a queue-based model.
// Rev 1.0
`default_nettype none

module tb_pc_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_enable = 1'b0;
  logic [31:0] jump_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] pc_o;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .ADDR_W    (32),
    .INST_W    (32),
    .RESET_PC  (32'h0),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .jump_enable    (jump_enable),
    .jump_target    (jump_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .pc_o           (pc_o)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model: fetch pointer, queue of delivered-but-unconsumed words, outstanding fetch (0 none, 1 live, 2 dead).
  logic [31:0] m_pc = '0;
  logic [31:0] m_req_pc = '0;
  int          m_out = 0;
  logic [31:0] q_pc[$];
  logic [31:0] q_data[$];

  // Memory: one pending fetch answered after a latency of 1..3 cycles.
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  int          mem_lat = 1;
  bit          mem_rand = 0;

  logic [31:0] acc_log[$];
  logic [31:0] del_log[$];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function bit e_req_valid();
    return !rst && !jump_enable && (m_out == 0) && (q_pc.size() < DEPTH);
  endfunction

  function bit e_inst_valid();
    return !rst && !jump_enable && (q_pc.size() != 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_valid", {31'd0, imem_req_valid}, {31'd0, e_req_valid()});
      if (e_req_valid()) chk("req_addr", imem_req_addr, m_pc);
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, e_inst_valid()});
      if (e_inst_valid()) begin
        chk("inst_pc", inst_pc, q_pc[0]);
        chk("inst_data", inst_data, q_data[0]);
      end
      chk("pc_o", pc_o, m_pc);
    end
    if (imem_req_valid && imem_req_ready) acc_log.push_back(imem_req_addr);
    if (inst_valid && inst_ready) del_log.push_back(inst_pc);
  end

  task automatic step();
    bit acc, rspv, pop;
    @(posedge clk);
    acc  = e_req_valid() && imem_req_ready;
    rspv = imem_rsp_valid;
    pop  = e_inst_valid() && inst_ready;
    if (rspv) mem_pend = 0;
    if (acc) begin
      mem_pend = 1;
      mem_addr = m_pc;
      mem_cnt  = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
    end
    if (rst) begin
      m_pc  = '0;
      m_out = 0;
      q_pc.delete();
      q_data.delete();
    end else if (jump_enable) begin
      m_pc = jump_target & ~32'd3;
      q_pc.delete();
      q_data.delete();
      if (m_out == 1) m_out = rspv ? 0 : 2;
      else if (m_out == 2 && rspv) m_out = 0;
    end else begin
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_data.pop_front());
      end
      if (acc) begin
        m_out    = 1;
        m_req_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end else if (m_out != 0 && rspv) begin
        if (m_out == 1) begin
          q_pc.push_back(m_req_pc);
          q_data.push_back(mdata(m_req_pc));
        end
        m_out = 0;
      end
    end
    #1;
    jump_enable    = 1'b0;
    imem_rsp_valid = 1'b0;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mdata(mem_addr);
      end
    end
  endtask

  task automatic reset_dut();
    rst            = 1'b1;
    jump_enable    = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    imem_rsp_valid = 1'b0;
    mem_pend       = 0;
    mem_rand       = 0;
    mem_lat        = 1;
    step();
    step();
    rst    = 1'b0;
    chk_en = 1;
  endtask

  initial begin
    // Sequential fetch, single-cycle memory, decode always ready.
    reset_dut();
    @(negedge clk);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst_data", inst_data, 32'h0);
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    acc_log.delete();
    del_log.delete();
    for (int i = 0; i < 20 && acc_log.size() < 3; i++) step();
    imem_req_ready = 1'b0;
    @(negedge clk);
    chk("t1_pc_after_3", pc_o, 32'hC);
    repeat (4) step();
    chk("t1_acc_n", acc_log.size(), 32'd3);
    chk("t1_del_n", del_log.size(), 32'd3);
    if (acc_log.size() >= 3 && del_log.size() >= 3) begin
      chk("t1_acc0", acc_log[0], 32'h0);
      chk("t1_acc1", acc_log[1], 32'h4);
      chk("t1_acc2", acc_log[2], 32'h8);
      chk("t1_del0", del_log[0], 32'h0);
      chk("t1_del1", del_log[1], 32'h4);
      chk("t1_del2", del_log[2], 32'h8);
    end

    // Decode stalled: buffer fills, issue stops, one pop frees a slot.
    reset_dut();
    imem_req_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    chk("t2_full_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("t2_full_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("t2_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    @(negedge clk);
    chk("t2_resume_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t2_resume_addr", imem_req_addr, 32'h8);

    // Redirect while a fetch is outstanding: its response is dropped.
    reset_dut();
    inst_ready  = 1'b1;
    jump_enable = 1'b1;
    jump_target = 32'h10;
    step();
    mem_lat        = 3;
    imem_req_ready = 1'b1;
    step();
    jump_enable = 1'b1;
    jump_target = 32'h203;
    step();
    @(negedge clk);
    chk("t3_pc_o", pc_o, 32'h200);
    chk("t3_drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
    acc_log.delete();
    del_log.delete();
    for (int i = 0; i < 20 && del_log.size() < 1; i++) step();
    chk("t3_del_n", del_log.size(), 32'd1);
    if (acc_log.size() >= 1 && del_log.size() >= 1) begin
      chk("t3_acc0", acc_log[0], 32'h200);
      chk("t3_del0", del_log[0], 32'h200);
    end

    // Redirect coinciding with a response and a non-empty buffer.
    reset_dut();
    imem_req_ready = 1'b1;
    repeat (3) step();
    jump_enable = 1'b1;
    jump_target = 32'h300;
    @(negedge clk);
    chk("t4_rsp_present", {31'd0, imem_rsp_valid}, 32'd1);
    chk("t4_gate_inst_valid", {31'd0, inst_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("t4_flushed", {31'd0, inst_valid}, 32'd0);
    chk("t4_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t4_req_addr", imem_req_addr, 32'h300);

    // PC wrap at the top of the address space.
    reset_dut();
    inst_ready  = 1'b1;
    jump_enable = 1'b1;
    jump_target = 32'hFFFF_FFFE;
    step();
    imem_req_ready = 1'b1;
    del_log.delete();
    step();
    imem_req_ready = 1'b0;
    @(negedge clk);
    chk("t5_wrap_pc", pc_o, 32'h0);
    repeat (3) step();
    chk("t5_del_n", del_log.size(), 32'd1);
    if (del_log.size() >= 1) chk("t5_del0", del_log[0], 32'hFFFF_FFFC);

    // Reset during an outstanding fetch; the late response must not be buffered.
    reset_dut();
    imem_req_ready = 1'b1;
    step();
    step();
    mem_lat = 3;
    step();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("t6_pc_o", pc_o, 32'h0);
    chk("t6_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("t6_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("t6_inst_data", inst_data, 32'h0);
    chk("t6_inst_pc", inst_pc, 32'h0);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("t6_stale_rsp", {31'd0, imem_rsp_valid}, 32'd1);
    step();
    @(negedge clk);
    chk("t6_no_push", {31'd0, inst_valid}, 32'd0);

    // Randomized traffic with redirects and back-pressure.
    reset_dut();
    mem_rand = 1;
    for (int c = 0; c < 4000; c++) begin
      imem_req_ready = ($urandom_range(0, 9) < 7);
      inst_ready     = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 11) == 0) begin
        jump_enable = 1'b1;
        jump_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom);
      end
      step();
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
